// File: rtl/crc16_frame_checker.sv
// Receive-side CRC16 checker for framed 16-bit word streams.
// Latency: result registered one cycle after the eof word; done pulses 2 cycles after eof.
// Backpressure: in_ready is decoded from state only and drops for the 2 cycles after eof.
//
// Ports:
//   clk, rst (async active-low)       - clock and reset
//   in_data/in_valid/in_sof/in_eof    - input word stream; eof word carries the received CRC
//   in_ready                          - word accepted when in_valid && in_ready
//   done                              - one-cycle pulse, results valid and held until next done
//   crc_ok/len_err/sof_err            - frame status
//   crc_out/word_cnt                  - computed CRC and number of data words counted
module crc16_frame_checker #(
  parameter logic [15:0] POLY      = 16'h1021,
  parameter logic [15:0] INIT      = 16'hFFFF,
  parameter int          MAX_WORDS = 256,
  localparam int         CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   in_data,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic          in_eof,
  output logic          in_ready,
  output logic          done,
  output logic          crc_ok,
  output logic          len_err,
  output logic          sof_err,
  output logic [15:0]   crc_out,
  output logic [CW-1:0] word_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_DRAIN, S_CHECK, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [15:0]   r_crc, w_crc;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [15:0]   r_rx_crc, w_rx_crc;
  logic          r_len_f, w_len_f;
  logic          r_sof_f, w_sof_f;

  logic          r_crc_ok, r_len_err, r_sof_err;
  logic [15:0]   r_crc_out;
  logic [CW-1:0] r_word_cnt;

  logic          w_acc;
  logic [15:0]   w_fold, w_start;

  // (x * 2^16) mod POLY: 16 LFSR shifts with zero input.
  function automatic logic [15:0] crc_step(input logic [15:0] x);
    logic [15:0] v;
    v = x;
    for (int i = 0; i < 16; i++) begin
      v = v[15] ? ((v << 1) ^ POLY) : (v << 1);
    end
    return v;
  endfunction

  assign in_ready = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_DRAIN);
  assign done     = (r_state == S_DONE);
  assign w_acc    = in_valid && in_ready;
  assign w_fold   = crc_step(r_crc ^ in_data);
  assign w_start  = crc_step(INIT ^ in_data);

  always_comb begin
    w_next   = r_state;
    w_crc    = r_crc;
    w_cnt    = r_cnt;
    w_rx_crc = r_rx_crc;
    w_len_f  = r_len_f;
    w_sof_f  = r_sof_f;
    case (r_state)
      S_IDLE: begin
        if (w_acc && in_sof) begin
          w_sof_f = 1'b0;
          if (in_eof) begin
            // Zero data words: report a length error with a clean CRC state.
            w_len_f  = 1'b1;
            w_crc    = INIT;
            w_cnt    = '0;
            w_rx_crc = in_data;
            w_next   = S_CHECK;
          end else begin
            w_len_f = 1'b0;
            w_crc   = w_start;
            w_cnt   = CW'(1);
            w_next  = S_DATA;
          end
        end
      end
      S_DATA, S_DRAIN: begin
        if (w_acc) begin
          if (in_eof) begin
            // eof takes precedence over a coincident sof.
            w_rx_crc = in_data;
            w_next   = S_CHECK;
          end else if (in_sof) begin
            // Abort current frame and restart with this word; flag reported at next done.
            w_sof_f = 1'b1;
            w_len_f = 1'b0;
            w_crc   = w_start;
            w_cnt   = CW'(1);
            w_next  = S_DATA;
          end else if (r_state == S_DATA) begin
            if (r_cnt < CW'(MAX_WORDS)) begin
              w_crc = w_fold;
              w_cnt = r_cnt + CW'(1);
            end else begin
              // Overflow word is not folded; drain the rest of the frame.
              w_len_f = 1'b1;
              w_next  = S_DRAIN;
            end
          end
        end
      end
      S_CHECK: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_crc    <= INIT;
      r_cnt    <= '0;
      r_rx_crc <= '0;
      r_len_f  <= 1'b0;
      r_sof_f  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_crc    <= w_crc;
      r_cnt    <= w_cnt;
      r_rx_crc <= w_rx_crc;
      r_len_f  <= w_len_f;
      r_sof_f  <= w_sof_f;
    end
  end

  // Results load on the edge that enters DONE and hold until the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_crc_ok   <= 1'b0;
      r_len_err  <= 1'b0;
      r_sof_err  <= 1'b0;
      r_crc_out  <= '0;
      r_word_cnt <= '0;
    end else if (r_state == S_CHECK) begin
      r_crc_ok   <= (r_crc == r_rx_crc) && !r_len_f;
      r_len_err  <= r_len_f;
      r_sof_err  <= r_sof_f;
      r_crc_out  <= r_crc;
      r_word_cnt <= r_cnt;
    end
  end

  assign crc_ok   = r_crc_ok;
  assign len_err  = r_len_err;
  assign sof_err  = r_sof_err;
  assign crc_out  = r_crc_out;
  assign word_cnt = r_word_cnt;

endmodule

// File: doc/crc16_frame_checker.md
# crc16_frame_checker

Receive-side CRC16 checker for framed 16-bit word streams. Consumes one data word per cycle and folds it into a running CRC16 using the same word-parallel update the transmit side uses: the intermediate value is data XOR previous CRC, followed by 16 polynomial steps. The final word of each frame is the transmitted CRC. The block compares it against the computed value and reports pass/fail, length and framing errors. It sits between the link deserializer and the frame consumer.

## Interface
- `POLY`, 16'h1021, CRC16 generator polynomial, normal (MSB-first) form, implicit x^16.
- `INIT`, 16'hFFFF, CRC register value at start of each frame.
- `MAX_WORDS`, 256, maximum data words per frame, excluding the CRC word; ≥ 1.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_data` input 16: stream word.
- `in_valid` input 1: `in_data`, `in_sof` and `in_eof` are valid.
- `in_sof` input 1: first data word of a frame.
- `in_eof` input 1: this word is the received CRC, i.e. the last word of the frame.
- `in_ready` output 1: block accepts a word this cycle. Transfer happens when `in_valid` and `in_ready` are both high.
- `done` output 1: one-cycle pulse; the result outputs below are valid and held until the next `done`.
- `crc_ok` output 1: computed CRC equals received CRC, and the frame had no error.
- `len_err` output 1: frame had 0 data words, or more than `MAX_WORDS` data words.
- `sof_err` output 1: previous frame was aborted by a new `in_sof` before its `in_eof`.
- `crc_out` output 16: computed CRC over the data words.
- `word_cnt` output clog2(`MAX_WORDS`+1): number of data words counted.

## Operation
- **Update rule.** `f(x) = (x · 2^16) mod POLY`, implemented as 16 unrolled LFSR shifts with zero input. For each accepted data word, `crc <= f(crc ^ in_data)`. The CRC word itself is not folded in.
- **States:** IDLE, DATA, DRAIN, CHECK, DONE.
- **IDLE** (`in_ready`=1):
  - Words without `in_sof` are discarded.
  - `in_sof` without `in_eof`: `crc <= f(INIT ^ in_data)`, `cnt <= 1`, clear the `sof_err` flag, go to DATA.
  - `in_sof` together with `in_eof`: zero data words. Set `len_err`, go to CHECK.
- **DATA** (`in_ready`=1):
  - `in_eof`: latch `rx_crc <= in_data`, go to CHECK. If `in_sof` is also set, it is ignored.
  - `in_sof` without `in_eof`: set the pending `sof_err` flag and restart the frame exactly as in IDLE with this word. No `done` is produced for the aborted frame. The flag is reported with the next `done`.
  - Other words with `cnt` < `MAX_WORDS`: `crc <= f(crc ^ in_data)`, `cnt <= cnt+1`.
  - Other words with `cnt` == `MAX_WORDS`: set `len_err`, go to DRAIN. The word is not folded into the CRC.
- **DRAIN** (`in_ready`=1): discard words until `in_eof`, then go to CHECK. `in_sof` in DRAIN is handled as in DATA, i.e. restart and flag `sof_err`.
- **CHECK** (`in_ready`=0):
  - Register the result outputs: `crc_ok = (crc == rx_crc) & !len_err`, `len_err`, `sof_err`, `crc_out = crc`, `word_cnt = cnt`.
  - Go to DONE.
- **DONE** (`in_ready`=0): `done`=1 for this cycle only, then go to IDLE.
- **Reset** (asynchronous, any state, including mid-frame):
  - State IDLE, `crc` = `INIT`, `cnt` = 0, `rx_crc` = 0.
  - All outputs 0 except `in_ready`, which is 1 once reset deasserts.
  - A partial frame is dropped without `done`.

## Timing
- Throughput is one data word per cycle. CRC update is a single-cycle combinational path into the `crc` register.
- If the `in_eof` word is accepted at edge N: CHECK occupies cycle N+1, and `done`=1 in cycle N+2 with results already valid.
- `in_ready` is low for exactly 2 cycles after `in_eof`, then high again, so the inter-frame gap is at least 2 cycles.
- `in_ready` is a registered function of state only; it does not depend on `in_valid`.
- Result outputs change only at the edge that enters DONE. They hold their values through IDLE until the next frame's DONE.

## Test plan
- **Single word, pass.** `INIT`=FFFF, frame [sof FFFF, eof 0000] → `done` 2 cycles after eof; `crc_out`=0000, `crc_ok`=1, `word_cnt`=1, `len_err`=0, `sof_err`=0.
- **Two words, pass.** `INIT`=FFFF, frame [sof FFFF, 0001, eof 1021] → `crc_out`=1021, `crc_ok`=1, `word_cnt`=2. Repeat with eof 1020 → `crc_ok`=0, `crc_out`=1021.
- **Zero-data frame.** Single beat with `in_sof`=`in_eof`=1 → `done`, `len_err`=1, `crc_ok`=0, `word_cnt`=0. Separately, `MAX_WORDS`=4 with 6 data words then eof → `len_err`=1, `word_cnt`=4, `crc_ok`=0, and exactly one `done`.
- **Abort by new sof.** [sof 1234, 5678, sof FFFF, eof 0000] → a single `done` with `crc_ok`=1, `sof_err`=1, `word_cnt`=1.
- **Backpressure and throughput.** Back-to-back frames with `in_valid` held high → `in_ready` low for exactly 2 cycles after each eof and no word lost. Random `in_valid` gaps inside a frame do not change `crc_out`.
- **Reset.** Assert `rst` low mid-frame (after 3 words) → outputs 0 immediately, without waiting for a clock edge. A fresh frame after release passes as in the first scenario, and no `done` is produced for the dropped frame.
